// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Holds FSM state encodings, controller opcodes and byte-enable patterns.
// Imported by the arbiter top level.
package mem_port_arbiter_pkg;

  // FSM state encoding (3-bit, kept as plain constants for legacy tools)
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_F_ADDR = 3'd1;
  localparam state_t S_F_WAIT = 3'd2;
  localparam state_t S_M_ADDR = 3'd3;
  localparam state_t S_M_WAIT = 3'd4;

  // Opcode values the pipeline controller already decodes
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  // Byte-enable patterns, same encoding as the M-stage write enable
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // True while a fetch owns the memory bus
  function automatic logic is_fetch_state(input state_t s);
    return (s == S_F_ADDR) || (s == S_F_WAIT);
  endfunction

endpackage

// File: rtl/mem_port_req_reg.sv
// Purpose: holds the address / byte enables / store data presented to memory.
// Latency: captures on the edge where load is high; outputs are pure flops.
// Backpressure: none here; the arbiter only loads it from IDLE.
module mem_port_req_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] we,
  input  logic [DATA_W-1:0]   wdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata
);

  // Request latch: stays stable for the whole transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
    end else if (load) begin
      mem_addr  <= addr;
      mem_we    <= we;
      mem_wdata <= wdata;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between fetch and M-stage accesses.
// Latency: zero-wait memory gives the valid pulse 3 cycles after the request edge.
// Backpressure: one transaction in flight; waiting stages see f_stall/m_stall.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_M_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  input  logic                f_flush,
  output logic [DATA_W-1:0]   f_rdata,
  output logic                f_valid,
  output logic                f_stall,
  input  logic                m_req,
  input  logic [DATA_W/8-1:0] m_we,
  input  logic [ADDR_W-1:0]   m_addr,
  input  logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_valid,
  output logic                m_stall,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int         STRB_W     = DATA_W / 8;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_M_STREAK);

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          m_streak;
  logic                discard;
  logic                f_pulse;
  logic                m_pulse;
  logic                in_idle;
  logic                pick_m;
  logic                pick_f;
  logic                f_done;
  logic                m_done;
  logic [ADDR_W-1:0]   sel_addr;
  logic [STRB_W-1:0]   sel_we;
  logic [DATA_W-1:0]   sel_wdata;

  // Arbitration and next-state: M wins unless F has waited out the streak limit
  always_comb begin
    in_idle   = (state == S_IDLE);
    pick_m    = in_idle & m_req & (~f_req | (m_streak < STREAK_MAX));
    pick_f    = in_idle & ~pick_m & f_req & ~f_flush;
    f_done    = (state == S_F_WAIT) & mem_rvalid;
    m_done    = (state == S_M_WAIT) & mem_rvalid;
    sel_addr  = pick_m ? m_addr  : f_addr;
    sel_we    = pick_m ? m_we    : '0;
    sel_wdata = pick_m ? m_wdata : '0;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_m)      state_nxt = S_M_ADDR;
        else if (pick_f) state_nxt = S_F_ADDR;
      end
      S_F_ADDR: if (mem_gnt)    state_nxt = S_F_WAIT;
      S_F_WAIT: if (mem_rvalid) state_nxt = S_IDLE;
      S_M_ADDR: if (mem_gnt)    state_nxt = S_M_WAIT;
      S_M_WAIT: if (mem_rvalid) state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // State register; mem_req is a flop so it is glitch-free while waiting for gnt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      mem_req <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_req <= (state_nxt == S_F_ADDR) || (state_nxt == S_M_ADDR);
    end
  end

  // Starvation guard: count M grants taken over a waiting fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_streak <= '0;
    end else if (in_idle) begin
      if (!f_req) begin
        m_streak <= '0;
      end else if (pick_m) begin
        if (m_streak < STREAK_MAX) m_streak <= m_streak + 4'd1;
      end else if (pick_f) begin
        m_streak <= '0;
      end
    end
  end

  // A redirect cannot withdraw the bus request, so remember to drop the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard <= 1'b0;
    end else if (f_done) begin
      discard <= 1'b0;
    end else if (is_fetch_state(state) && f_flush) begin
      discard <= 1'b1;
    end
  end

  // Fetch completion: capture the instruction word unless it was redirected
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_pulse <= 1'b0;
      f_rdata <= '0;
    end else begin
      f_pulse <= f_done & ~(discard | f_flush);
      if (f_done && !(discard || f_flush)) f_rdata <= mem_rdata;
    end
  end

  // Data completion: loads update m_rdata, stores only acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pulse <= 1'b0;
      m_rdata <= '0;
    end else begin
      m_pulse <= m_done;
      if (m_done && (mem_we == '0)) m_rdata <= mem_rdata;
    end
  end

  mem_port_req_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pick_m | pick_f),
    .addr      (sel_addr),
    .we        (sel_we),
    .wdata     (sel_wdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  // A redirect arriving with the pulse still kills the instruction
  assign f_valid = f_pulse & ~f_flush;
  assign m_valid = m_pulse;
  assign f_stall = f_req & ~f_valid;
  assign m_stall = m_req & ~m_valid;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory with tunable grant/response
// delay, requester tasks, and a scoreboard of expected read data per port.
// Completion order and grant order are logged for the arbitration checks.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_req = 1'b0, f_flush = 1'b0, f_valid, f_stall;
  logic [31:0] f_addr = '0, f_rdata;
  logic        m_req = 1'b0, m_valid, m_stall;
  logic [3:0]  m_we = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata;
  logic        mem_req, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_M_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_rdata(f_rdata),
    .f_valid(f_valid), .f_stall(f_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_valid(m_valid), .m_stall(m_stall),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural memory ----------------
  logic [31:0] mem [logic [31:0]];
  int gnt_dly = 0;
  int rv_lat  = 0;
  bit stray   = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A50000;
  endfunction

  initial begin
    bit          pend = 1'b0;
    int          gcnt = 0, rcnt = 0;
    logic [31:0] p_addr = '0, p_wd = '0, v;
    logic [3:0]  p_we = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!rst) begin
        pend = 1'b0; gcnt = 0;
        continue;
      end
      if (stray) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; stray = 1'b0;
      end else if (pend) begin
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          if (p_we == 4'b0) begin
            mem_rdata = rd(p_addr);
          end else begin
            v = rd(p_addr);
            for (int b = 0; b < 4; b++) if (p_we[b]) v[8*b +: 8] = p_wd[8*b +: 8];
            mem[p_addr] = v;
          end
          pend = 1'b0;
        end else begin
          rcnt--;
        end
      end else if (mem_req) begin
        if (gcnt >= gnt_dly) begin
          mem_gnt = 1'b1; pend = 1'b1; rcnt = rv_lat; gcnt = 0;
          p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
        end else begin
          gcnt++;
        end
      end
    end
  end

  // ---------------- scoreboard and logs ----------------
  logic [31:0] f_exp[$];
  logic [31:0] m_exp[$];
  logic [31:0] grant_log[$];
  bit          done_log[$];   // 1 = M completion, 0 = F completion
  logic        req_q = 1'b0;
  logic [31:0] last_ld = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (f_valid) begin
        if (f_exp.size() == 0) chk("f_unexpected", 1, 0);
        else chk("f_rdata", f_rdata, f_exp.pop_front());
        done_log.push_back(1'b0);
      end
      if (m_valid) begin
        if (m_exp.size() == 0) chk("m_unexpected", 1, 0);
        else chk("m_rdata", m_rdata, m_exp.pop_front());
        done_log.push_back(1'b1);
      end
      if (mem_req && !req_q) grant_log.push_back(mem_addr);
    end
    req_q = mem_req;
  end

  // ---------------- requester tasks ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic fetch(input logic [31:0] a);
    int n = 0;
    f_addr = a; f_req = 1'b1;
    f_exp.push_back(rd(a));
    do begin tick(); n++; end while (!f_valid && n < 100);
    if (!f_valid) chk("f_timeout", 0, 1);
  endtask

  task automatic m_op(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    m_we = we; m_addr = a; m_wdata = wd; m_req = 1'b1;
    if (we == 4'b0) last_ld = rd(a);
    m_exp.push_back(last_ld);
    do begin tick(); n++; end while (!m_valid && n < 100);
    if (!m_valid) chk("m_timeout", 0, 1);
  endtask

  initial begin #400000; $display("FAIL watchdog expired"); $fatal(1, "watchdog"); end

  // ---------------- test sequence ----------------
  initial begin
    int g0, d0, n;
    logic prev_rv;
    bit   exp_m [6] = '{1, 1, 1, 1, 0, 1};
    mem[32'h100]  = 32'h00500093;
    mem[32'h104]  = 32'h00100113;
    mem[32'h200]  = 32'h11122233;
    mem[32'h300]  = 32'h00C00293;
    mem[32'h2000] = 32'hCAFEF00D;
    mem[32'h2004] = 32'h11111111;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req", mem_req, 0);  chk("rst_busy", busy, 0);
    chk("rst_f_valid", f_valid, 0);  chk("rst_m_valid", m_valid, 0);
    chk("rst_f_rdata", f_rdata, 0);  chk("rst_m_rdata", m_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;
    tick();

    // fetch only, zero-wait: valid in cycle 3, stall in cycles 0..2
    f_addr = 32'h100; f_req = 1'b1; f_exp.push_back(rd(32'h100));
    #1; chk("t1_stall_c0", f_stall, 1);
    tick(); chk("t1_stall_c1", f_stall, 1); chk("t1_mem_req_c1", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100); chk("t1_mem_we", mem_we, 0); chk("t1_busy", busy, 1);
    tick(); chk("t1_stall_c2", f_stall, 1); chk("t1_valid_c2", f_valid, 0);
    tick(); chk("t1_valid_c3", f_valid, 1); chk("t1_rdata_c3", f_rdata, 32'h00500093);
    chk("t1_stall_c3", f_stall, 0);
    f_req = 1'b0;
    tick(); chk("t1_pulse_len", f_valid, 0); chk("t1_idle", busy, 0);

    // simultaneous F and M: M first, F granted in the m_valid cycle
    rv_lat = 2; d0 = done_log.size();
    fork
      begin fetch(32'h104); f_req = 1'b0; end
      begin
        m_op(4'b0, 32'h2000, 0); m_req = 1'b0;
        tick(); chk("t2_f_gnt_req", mem_req, 1); chk("t2_f_gnt_addr", mem_addr, 32'h104);
      end
    join
    if (done_log.size() > d0) chk("t2_m_first", done_log[d0], 1);
    else chk("t2_done_cnt", done_log.size(), d0 + 1);

    // starvation guard: M,M,M,M,F,M
    tick(); rv_lat = 0; g0 = grant_log.size();
    fork
      begin
        fetch(32'h180); f_req = 1'b0;
        chk("t3_streak_clr", {28'b0, dut.m_streak}, 0);
      end
      begin
        for (int i = 0; i < 6; i++) m_op(4'b0, 32'h2100 + 4 * i, 0);
        m_req = 1'b0;
      end
    join
    if (grant_log.size() < g0 + 6) chk("t3_grants", grant_log.size(), g0 + 6);
    else for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), grant_log[g0 + i] >= 32'h2000, exp_m[i]);

    // flush during F_WAIT: 0x200 dropped, 0x300 returned
    tick(); rv_lat = 3;
    f_addr = 32'h200; f_req = 1'b1;
    tick(); tick();
    chk("t4_in_wait", busy & ~mem_req, 1); chk("t4_addr", mem_addr, 32'h200);
    f_flush = 1'b1; f_addr = 32'h300; f_exp.push_back(rd(32'h300));
    tick(); f_flush = 1'b0;
    n = 0;
    while (!f_valid && n < 100) begin tick(); n++; end
    chk("t4_valid", f_valid, 1); chk("t4_valid_addr", mem_addr, 32'h300);
    f_req = 1'b0;

    // flush coincident with the valid pulse masks it
    tick(); rv_lat = 0;
    f_addr = 32'h100; f_req = 1'b1;
    tick(); tick(); tick();
    f_flush = 1'b1; #1; chk("t5_masked", f_valid, 0);
    tick(); f_flush = 1'b0; f_req = 1'b0; chk("t5_no_late", f_valid, 0);

    // stray rvalid in IDLE is ignored
    tick(); stray = 1'b1;
    tick(); tick(); chk("t6_f_quiet", f_valid, 0); chk("t6_m_quiet", m_valid, 0);
    chk("t6_busy", busy, 0);

    // store: halfword enables latched, ack one cycle after rvalid, m_rdata held
    rv_lat = 1;
    m_we = BE_H; m_addr = 32'h2004; m_wdata = 32'hABCD1234; m_req = 1'b1;
    m_exp.push_back(last_ld);
    tick();
    chk("t7_req", mem_req, 1); chk("t7_we", mem_we, 4'b0011);
    chk("t7_addr", mem_addr, 32'h2004); chk("t7_wdata", mem_wdata, 32'hABCD1234);
    n = 0; prev_rv = 1'b0;
    while (!m_valid && n < 100) begin prev_rv = mem_rvalid; tick(); n++; end
    chk("t7_valid", m_valid, 1); chk("t7_after_rv", prev_rv, 1);
    chk("t7_rdata_held", m_rdata, last_ld);
    m_req = 1'b0; m_we = 4'b0;
    tick(); chk("t7_pulse_len", m_valid, 0);
    chk("t7_mem", rd(32'h2004), 32'h11111234);

    // reset in M_WAIT abandons the load
    rv_lat = 5;
    m_addr = 32'h2000; m_req = 1'b1;
    tick(); tick();
    chk("t8_in_wait", busy & ~mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("t8_mem_req", mem_req, 0); chk("t8_busy", busy, 0); chk("t8_m_valid", m_valid, 0);
    chk("t8_mem_addr", mem_addr, 0);
    m_req = 1'b0;
    @(posedge clk); #4 rst = 1'b1;
    last_ld = '0;
    rv_lat = 0;
    tick();
    fetch(32'h100); f_req = 1'b0;
    chk("t8_fetch_rdata", f_rdata, 32'h00500093);
    tick(); tick();
    chk("f_exp_left", f_exp.size(), 0);
    chk("m_exp_left", m_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
